// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared RAM-port constants, FSM encoding, request-legality check |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 1024;
  localparam int LEN_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Legal when the whole burst lies inside 0..depth-1 (no wrap) and writes are single-beat.
  function automatic logic req_legal(input logic              wr,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len,
                                     input logic [31:0]       depth);
    logic [31:0] w_first;
    logic [31:0] w_last;
    w_first = 32'(addr);
    w_last  = w_first + 32'(len);
    return (w_first < depth) && (w_last < depth) && !(wr && (len != '0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rsp_skid : 2-entry FIFO of {last,data} read beats with flush          |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module mem_rsp_skid #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [DATA_W:0] r_mem [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic            w_pop;

  assign w_pop = pop && (r_count != 2'd0);

  always_ff @(posedge CLK) begin
    if (flush) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= {push_last, push_data};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rptr][DATA_W-1:0];
  assign head_last = r_mem[r_rptr][DATA_W];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_master : CPU-side initiator for the synchronous RAM port; single      |
// |              writes and 1..16-beat incrementing read bursts               |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module mem_master #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int LEN_W     = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              err,
  output logic              busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Data_out
);

  import mem_pkg::*;

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_left;
  logic [DATA_W-1:0] r_wdata;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_err;

  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_last;
  logic              w_accept;
  logic              w_legal;
  logic              w_rsp_valid;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;

  assign req_ready   = (r_state == S_IDLE) && !reset;
  assign w_accept    = req_valid && req_ready;
  assign w_legal     = req_legal(req_write, req_addr, req_len, 32'(MEM_DEPTH));
  assign w_rsp_valid = (w_count != 2'd0);
  assign w_pop       = w_rsp_valid && rsp_ready;

  // A beat popped this cycle frees its slot before the next capture, which keeps
  // one beat per cycle with a 2-entry FIFO while never overfilling it.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RD) && (w_occ < 3'd2);

  always_comb begin
    w_state_nx = r_state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ADDR       = '0;
    Data_in    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          w_state_nx = req_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        MemWrite   = 1'b1;
        ADDR       = r_addr;
        Data_in    = r_wdata;
        w_state_nx = S_IDLE;
      end
      S_RD: begin
        if (w_issue) begin
          MemRead = 1'b1;
          ADDR    = r_addr;
          if (r_left == '0) begin
            w_state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!r_inflight && (w_count == {1'b0, w_pop})) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_left          <= '0;
      r_wdata         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_err           <= w_accept && !w_legal;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_left == '0);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_left  <= req_len;
        r_wdata <= req_wdata;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
    end
  end

  mem_rsp_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .CLK       (CLK),
    .flush     (reset),
    .push      (r_inflight),
    .push_data (Data_out),
    .push_last (r_inflight_last),
    .pop       (w_pop),
    .head_data (w_head_data),
    .head_last (w_head_last),
    .count     (w_count)
  );

  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = w_rsp_valid ? w_head_data : '0;
  assign rsp_last  = w_rsp_valid && w_head_last;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_master : directed self-checking bench with a 1024x16 RAM model     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_master;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        err;
  logic        busy;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ADDR;
  logic [15:0] Data_in;
  logic [15:0] Data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_err = 0, n_both = 0;
  logic [16:0] q[$];
  int          qc[$];
  logic [15:0] ram [1024];

  mem_master dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .err       (err),
    .busy      (busy),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ADDR      (ADDR),
    .Data_in   (Data_in),
    .Data_out  (Data_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (MemWrite) ram[ADDR[9:0]] <= Data_in;
    if (MemRead)  Data_out <= ram[ADDR[9:0]];
  end

  always @(negedge CLK) begin
    if (MemRead)              n_rd++;
    if (MemWrite)             n_wr++;
    if (err)                  n_err++;
    if (MemRead && MemWrite)  n_both++;
    if (rsp_valid && rsp_ready) begin
      q.push_back({rsp_last, rsp_rdata});
      qc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge CLK);
    n_rd = 0; n_wr = 0; n_err = 0;
    q.delete(); qc.delete();
  endtask

  // Returns just after the accepting edge; acc is the cycle index of that edge.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [3:0] l,
                        input logic [15:0] d, output int acc);
    int n;
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready_timeout", n < 50, 1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
    acc = cyc;
  endtask

  task automatic wait_idle(output int idle_cyc);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    idle_cyc = cyc;
    chk("idle_timeout", n < 200, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_outs"},
        {req_ready, rsp_valid, rsp_last, err, busy, MemRead, MemWrite},
        7'b1000000);
    chk({tag, "_addr_din"}, {ADDR, Data_in}, 32'h0);
    chk({tag, "_rdata"}, rsp_rdata, 16'h0);
  endtask

  initial begin
    int acc, idl;
    logic [16:0] exp4 [4];
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 3 + 16'h100);
    ram[25] = 16'd0; ram[26] = 16'd6; ram[27] = 16'd4; ram[28] = 16'd5;
    ram[29] = 16'd6; ram[30] = 16'd7; ram[31] = 16'd8;
    ram[1023] = 16'h1234;
    exp4[0] = {1'b0, 16'd0}; exp4[1] = {1'b0, 16'd6};
    exp4[2] = {1'b0, 16'd4}; exp4[3] = {1'b1, 16'd5};

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready_low", req_ready, 0);
    chk("rst_strobes", {MemRead, MemWrite, busy, rsp_valid, err}, 0);
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    chk_idle_outputs("post_reset");

    // single write, then read-back
    clear_mon();
    do_req(1'b1, 16'h0010, 4'd0, 16'hBEEF, acc);
    @(negedge CLK);
    chk("wr_cycle", {MemWrite, MemRead, busy}, 3'b101);
    chk("wr_addr_data", {ADDR, Data_in}, {16'h0010, 16'hBEEF});
    wait_idle(idl);
    chk("wr_counts", {8'(n_wr), 8'(n_rd), 8'(q.size())}, {8'd1, 8'd0, 8'd0});
    clear_mon();
    do_req(1'b0, 16'h0010, 4'd0, 16'h0, acc);
    wait_idle(idl);
    chk("rdback_n", q.size(), 1);
    if (q.size() == 1) chk("rdback_val", q[0], {1'b1, 16'hBEEF});

    // 4-beat burst at full throughput
    clear_mon();
    do_req(1'b0, 16'd25, 4'd3, 16'h0, acc);
    wait_idle(idl);
    chk("b4_n", q.size(), 4);
    if (q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("b4_beat%0d", i), q[i], exp4[i]);
      chk("b4_first_lat", qc[0] - acc, 2);
      chk("b4_last_lat", qc[3] - acc, 5);
    end
    chk("b4_ready_again", idl - acc, 6);
    chk("b4_rd_err", {8'(n_rd), 8'(n_err)}, {8'd4, 8'd0});

    // same burst with consumer stalls: MemRead must stop at FIFO full
    clear_mon();
    do_req(1'b0, 16'd25, 4'd3, 16'h0, acc);
    @(posedge CLK); #1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stall_rd_count", n_rd, 2);
    chk("stall_memread_low", {MemRead, rsp_valid}, 2'b01);
    @(posedge CLK); #1 rsp_ready = 1'b1;
    wait_idle(idl);
    chk("stall_n", q.size(), 4);
    if (q.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("stall_beat%0d", i), q[i], exp4[i]);
    chk("stall_rd_total", n_rd, 4);

    // out-of-range burst and multi-beat write are rejected
    clear_mon();
    do_req(1'b0, 16'd1020, 4'd7, 16'h0, acc);
    @(negedge CLK);
    chk("rej_rd_pulse", {err, busy, req_ready}, 3'b101);
    @(negedge CLK);
    chk("rej_rd_pulse_end", err, 0);
    repeat (3) @(negedge CLK);
    chk("rej_rd_counts", {8'(n_err), 8'(n_rd), 8'(q.size())}, {8'd1, 8'd0, 8'd0});
    clear_mon();
    do_req(1'b1, 16'h0020, 4'd2, 16'h5555, acc);
    repeat (4) @(negedge CLK);
    chk("rej_wr_counts", {8'(n_err), 8'(n_wr)}, {8'd1, 8'd0});

    // top-of-memory boundary
    clear_mon();
    do_req(1'b0, 16'd1023, 4'd0, 16'h0, acc);
    wait_idle(idl);
    chk("top_legal", {8'(n_err), 8'(q.size())}, {8'd0, 8'd1});
    if (q.size() == 1) chk("top_val", q[0], {1'b1, 16'h1234});
    clear_mon();
    do_req(1'b0, 16'd1024, 4'd0, 16'h0, acc);
    repeat (4) @(negedge CLK);
    chk("oob_err", {8'(n_err), 8'(n_rd), 8'(q.size())}, {8'd1, 8'd0, 8'd0});

    // reset in the middle of a burst
    clear_mon();
    rsp_ready = 1'b0;
    do_req(1'b0, 16'd25, 4'd6, 16'h0, acc);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    chk_idle_outputs("midrst");
    rsp_ready = 1'b1;
    repeat (5) @(negedge CLK);
    chk("midrst_no_rsp", q.size(), 0);
    clear_mon();
    do_req(1'b0, 16'd28, 4'd1, 16'h0, acc);
    wait_idle(idl);
    chk("midrst_new_n", q.size(), 2);
    if (q.size() == 2) begin
      chk("midrst_new0", q[0], {1'b0, 16'd5});
      chk("midrst_new1", q[1], {1'b1, 16'd6});
    end

    chk("never_both_strobes", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
